// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: decode-stage hazard inputs, memory/halt status in,
// latch enables/flushes, performance counters and scoreboard view out.
interface hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_regwr;
    logic             id_memread;
    logic             ex_redirect;
    logic             ihit;
    logic             mem_dreq;
    logic             dhit;
    logic             wb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] load_stalls;
    logic [CNT_W-1:0] redirects;
    logic             halted;
    // Scoreboard entries {valid, dest, regwr, memread}, visible to the bypass unit
    logic [REG_W+2:0] sb_ex;
    logic [REG_W+2:0] sb_mem;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_regwr, id_memread,
        output ex_redirect, ihit, mem_dreq, dhit, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        input  load_stalls, redirects, halted, sb_ex, sb_mem
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_regwr, id_memread,
        input  ex_redirect, ihit, mem_dreq, dhit, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        output load_stalls, redirects, halted, sb_ex, sb_mem
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: load-use bubbles, redirect squashes,
// data-miss freeze and halt latch, with an EX/MEM destination scoreboard.
module hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic          CLK,
    input logic          nRST,
    hazard_unit_if.slave hu
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             regwr;
        logic             memread;
    } sb_t;

    state_e           state_q, state_d;
    sb_t              ex_q, ex_d, mem_q, mem_d;
    logic [CNT_W-1:0] ls_q, ls_d, rd_q, rd_d;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic ls_inc, rd_inc;
    logic rs_match, rt_match, lu_hit, run_eval;

    assign rs_match = (hu.id_rs == ex_q.dest);
    assign rt_match = (hu.id_rt == ex_q.dest);
    assign lu_hit   = hu.id_valid & ex_q.valid & ex_q.memread & ex_q.regwr &
                      (ex_q.dest != '0) & (rs_match | (hu.id_uses_rt & rt_match));

    // Normal priority rules apply in RUN without a new miss, or on the dhit cycle
    // that ends a miss; halt still overrides both.
    assign run_eval = !hu.wb_halt &&
                      (((state_q == RUN) && !(hu.mem_dreq && !hu.dhit)) ||
                       ((state_q == DWAIT) && hu.dhit));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (hu.wb_halt)                   state_d = HALTED;
                else if (hu.mem_dreq && !hu.dhit) state_d = DWAIT;
            end
            DWAIT: begin
                if (hu.dhit) state_d = hu.wb_halt ? HALTED : RUN;
            end
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        ls_inc     = 1'b0;
        rd_inc     = 1'b0;
        if (run_eval) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (hu.ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                rd_inc     = 1'b1;
            end else if (lu_hit) begin
                // Single bubble: MEM->EX bypass covers the load on the next cycle
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                ls_inc     = 1'b1;
            end else if (!hu.ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d = ex_q;
        if (idex_flush) begin
            ex_d = '0;
        end else if (idex_en) begin
            ex_d.valid   = hu.id_valid;
            ex_d.dest    = hu.id_dest;
            ex_d.regwr   = hu.id_regwr;
            ex_d.memread = hu.id_memread;
        end
        mem_d = exmem_en ? ex_q : mem_q;
        ls_d  = (ls_inc && (ls_q != '1)) ? ls_q + CNT_W'(1) : ls_q;
        rd_d  = (rd_inc && (rd_q != '1)) ? rd_q + CNT_W'(1) : rd_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_q  <= '0;
            mem_q <= '0;
            ls_q  <= '0;
            rd_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            ls_q  <= ls_d;
            rd_q  <= rd_d;
        end
    end

    assign hu.pc_en       = pc_en;
    assign hu.ifid_en     = ifid_en;
    assign hu.idex_en     = idex_en;
    assign hu.exmem_en    = exmem_en;
    assign hu.memwb_en    = memwb_en;
    assign hu.ifid_flush  = ifid_flush;
    assign hu.idex_flush  = idex_flush;
    assign hu.load_stalls = ls_q;
    assign hu.redirects   = rd_q;
    assign hu.halted      = (state_q == HALTED);
    assign hu.sb_ex       = ex_q;
    assign hu.sb_mem      = mem_q;
endmodule
